// File: rtl/manchester_transmitter_if.sv
// manchester_transmitter_if: parallel word handshake into the Manchester transmitter
interface manchester_transmitter_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   modport master (output tx_data, tx_valid, input tx_ready);
   modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/manchester_transmitter.sv
// manchester_transmitter: sync rise, half-cell start bit, MSB-first Manchester data, then a forced-low gap
module manchester_transmitter #(
   parameter int DATA_WIDTH  = 8,
   parameter int HALF_PERIOD = 9,
   parameter int GAP_CYCLES  = 36
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             enable,
   manchester_transmitter_if.slave          tx,
   output logic                             manchester_out,
   output logic                             busy,
   output logic                             transmission_done
);
   localparam int HW = $clog2(HALF_PERIOD);
   localparam int GW = $clog2(GAP_CYCLES);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   typedef enum logic [2:0] {IDLE, START, FIRST_HALF, SECOND_HALF, GAP} state_t;
   state_t                state, state_n;
   logic [HW-1:0]         half_cnt, half_n;
   logic [GW-1:0]         gap_cnt, gap_n;
   logic [BW-1:0]         bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic                  out_n, done_n, half_wrap, in_cell;
   assign tx.tx_ready = (state == IDLE) && !reset;
   assign busy        = state != IDLE;
   assign half_wrap   = half_cnt == HW'(HALF_PERIOD - 1);
   assign in_cell     = state == START || state == FIRST_HALF || state == SECOND_HALF;
   // line value is derived from the current state, so it lags the state transition by one clock
   always_comb begin
      state_n = state;
      shift_n = shift;
      bit_n   = bit_cnt;
      gap_n   = gap_cnt;
      done_n  = 1'b0;
      half_n  = in_cell ? (half_wrap ? '0 : half_cnt + 1'b1) : '0;
      out_n   = state == START || (state == FIRST_HALF && shift[DATA_WIDTH-1]) ||
                (state == SECOND_HALF && !shift[DATA_WIDTH-1]);
      case (state)
         IDLE: if (tx.tx_valid) begin
            state_n = START;
            shift_n = tx.tx_data;
            bit_n   = '0;
            gap_n   = '0;
         end
         START:      state_n = half_wrap ? FIRST_HALF : START;
         FIRST_HALF: state_n = half_wrap ? SECOND_HALF : FIRST_HALF;
         SECOND_HALF: if (half_wrap) begin
            shift_n = shift << 1;
            bit_n   = bit_cnt + 1'b1;
            state_n = bit_cnt == BW'(DATA_WIDTH - 1) ? GAP : FIRST_HALF;
         end
         GAP: begin
            done_n  = gap_cnt == GW'(GAP_CYCLES - 1);
            gap_n   = done_n ? '0 : gap_cnt + 1'b1;
            state_n = done_n ? IDLE : GAP;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         half_cnt          <= '0;
         gap_cnt           <= '0;
         bit_cnt           <= '0;
         shift             <= '0;
         manchester_out    <= 1'b0;
         transmission_done <= 1'b0;
      end else begin
         transmission_done <= enable && done_n;
         if (enable) begin
            state          <= state_n;
            half_cnt       <= half_n;
            gap_cnt        <= gap_n;
            bit_cnt        <= bit_n;
            shift          <= shift_n;
            manchester_out <= out_n;
         end
      end
   end
endmodule
